serial_alu_seq: RTL and testbench

Bit-serial word ALU sequencer that drives a single 1-bit ALU slice across a WIDTH-bit word, LSB first, one bit per clock. It accepts a word-level command with a start/busy/done handshake and chains the carry through a flip-flop. It returns the assembled result word and final carry. It is the word-level master for the team's 1-bit ALU slice, which consumes the per-bit inputs and produces the y/z outputs.

---
 rtl/serial_alu_seq.sv | 115 +++++++++++
 tb/tb_serial_alu_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/serial_alu_seq.sv
// Bit-serial word ALU sequencer: streams a WIDTH-bit command LSB first through
// a 1-bit ALU slice, chaining the carry through a flip-flop.

module serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    // state | meaning
    // IDLE  | waiting for start; result/cout hold the last completed command
    // RUN   | one bit processed per clock, LSB first
    // DONE  | one-cycle done pulse, then back to IDLE

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [1:0]       op_q;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic slice_y;
    logic slice_z;
    logic res_bit;
    logic carry_next;

    // Single-bit ALU slice fed from the operand shift registers and carry FF.
    always_comb begin
        slice_y = 1'b0;
        slice_z = 1'b0;
        case (op_q)
            2'b00: begin
                slice_y = a_sh[0] ^ b_sh[0] ^ carry;
                slice_z = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
            end
            2'b01: slice_y = a_sh[0] & b_sh[0];
            2'b10: slice_y = ~a_sh[0];
            default: slice_z = a_sh[0] ^ b_sh[0];
        endcase
        res_bit    = (op_q == 2'b11) ? slice_z : slice_y;
        carry_next = (op_q == 2'b00) ? slice_z : 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            op_q   <= 2'b00;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        op_q  <= op;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    result <= {res_bit, result[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= carry_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        cout  <= carry_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Self-checking bench for serial_alu_seq: directed plan vectors plus random
// commands against a word-level arithmetic reference model.

module tb_serial_alu_seq;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;

    int n_checks = 0;
    int n_fail   = 0;

    serial_alu_seq #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Word-level reference: {cout, result}
    function automatic logic [WIDTH:0] ref_alu(input logic [1:0] f, input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y, input logic ci);
        case (f)
            2'b00:   return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
            2'b01:   return {1'b0, x & y};
            2'b10:   return {1'b0, ~x};
            default: return {1'b0, x ^ y};
        endcase
    endfunction

    always @(negedge clk) check("busy_done_excl", {31'd0, busy & done}, 32'd0);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        a   = WIDTH'($urandom);
        b   = WIDTH'($urandom);
        op  = 2'($urandom);
        cin = 1'($urandom);
    endtask

    // mode 0: quiet; 1: stray starts before edges 3 and WIDTH+1; 2: random stray starts
    task automatic run_cmd(input logic [1:0] f, input logic [WIDTH-1:0] x,
                           input logic [WIDTH-1:0] y, input logic ci, input int mode);
        logic [WIDTH:0] exp;
        int done_edge;
        exp = ref_alu(f, x, y, ci);
        op = f; a = x; b = y; cin = ci; start = 1'b1;
        step();
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("accept_done", {31'd0, done}, 32'd0);
        done_edge = 0;
        for (int e = 1; e <= 3 * WIDTH; e++) begin
            scramble_inputs();
            case (mode)
                1:       start = (e == 3);
                2:       start = 1'($urandom);
                default: start = 1'b0;
            endcase
            step();
            if (done) begin
                done_edge = e;
                break;
            end
            check("run_busy", {31'd0, busy}, 32'd1);
        end
        check("done_edge", done_edge, WIDTH);
        check("result", {24'd0, result}, {24'd0, exp[WIDTH-1:0]});
        check("cout", {31'd0, cout}, {31'd0, exp[WIDTH]});
        check("done_busy", {31'd0, busy}, 32'd0);
        scramble_inputs();
        start = (mode != 0);
        step();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("start_in_done_ignored", {31'd0, busy}, 32'd0);
        check("result_hold", {24'd0, result}, {24'd0, exp[WIDTH-1:0]});
        check("cout_hold", {31'd0, cout}, {31'd0, exp[WIDTH]});
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; cin = 1'b0;
        step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        reset = 1'b0;
        step();

        run_cmd(2'b00, 8'h5A, 8'h3C, 1'b0, 0);
        check("plan_add", {23'd0, cout, result}, 32'h096);
        run_cmd(2'b00, 8'hFF, 8'h01, 1'b0, 0);
        check("plan_add_wrap", {23'd0, cout, result}, 32'h100);
        run_cmd(2'b00, 8'h00, 8'h00, 1'b1, 0);
        check("plan_add_cin", {23'd0, cout, result}, 32'h001);
        run_cmd(2'b00, 8'hFF, 8'h01, 1'b0, 0);
        run_cmd(2'b01, 8'h5A, 8'h3C, 1'b0, 0);
        check("plan_and", {23'd0, cout, result}, 32'h018);
        run_cmd(2'b10, 8'h5A, 8'h3C, 1'b1, 0);
        check("plan_not", {23'd0, cout, result}, 32'h0A5);
        run_cmd(2'b11, 8'h5A, 8'h3C, 1'b1, 0);
        check("plan_xor", {23'd0, cout, result}, 32'h066);

        // stray starts during RUN/DONE, then back-to-back accept at edge WIDTH+2
        run_cmd(2'b00, 8'hC3, 8'h7E, 1'b1, 1);
        run_cmd(2'b11, 8'hF0, 8'h0F, 1'b0, 0);

        // reset mid-add at edge 4
        op = 2'b00; a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        @(posedge clk);
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_result", {24'd0, result}, 32'd0);
        check("midrst_cout", {31'd0, cout}, 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            step();
            check("no_done_after_rst", {30'd0, busy, done}, 32'd0);
        end
        run_cmd(2'b00, 8'h12, 8'h34, 1'b1, 0);
        check("post_rst_add", {23'd0, cout, result}, 32'h047);

        for (int t = 0; t < 40; t++)
            run_cmd(2'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
